// File: rtl/phy_tx_pkg.sv
// Shared phy_tx definitions: byte geometry, idle symbol and L1 mux states.
package phy_tx_pkg;

    localparam int BYTE_W = 8;
    localparam logic [7:0] IDLE_BYTE = 8'hBC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2
    } l1_state_e;

endpackage

// File: rtl/mux_l1_tx_rr_arb2.sv
// Two-requester round-robin arbiter; the last winner is kept by the caller.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       rr_last,
    output logic       gnt,
    output logic       any
);

    always_comb begin
        gnt = 1'b0;
        unique case (req)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~rr_last;
            default: gnt = 1'b0;
        endcase
    end

    assign any = |req;

endmodule

// File: rtl/mux_l1_tx.sv
// Transmit L1 muxer: picks a lane per 16-bit word and emits it
// as two bytes, high byte first, with no gap between words.
module mux_l1_tx #(
    parameter int                BYTE_W    = phy_tx_pkg::BYTE_W,
    parameter logic [BYTE_W-1:0] IDLE_BYTE = phy_tx_pkg::IDLE_BYTE
) (
    input  logic                  clk_4f,
    input  logic                  reset,
    input  logic [2*BYTE_W-1:0]   data_l0,
    input  logic                  valid_l0,
    output logic                  ready_l0,
    input  logic [2*BYTE_W-1:0]   data_l1,
    input  logic                  valid_l1,
    output logic                  ready_l1,
    output logic [BYTE_W-1:0]     data_mux_l1,
    output logic                  valid_mux_l1,
    output logic                  lane_mux_l1
);

    import phy_tx_pkg::*;

    l1_state_e           state_q, state_d;
    logic [BYTE_W-1:0]   hold_q, hold_d;
    logic [BYTE_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                lane_q, lane_d;
    logic                rr_last_q, rr_last_d;

    logic                gnt;
    logic                any;
    logic                can_accept;
    logic [2*BYTE_W-1:0] word;

    rr_arb2 u_arb (
        .req     ({valid_l1, valid_l0}),
        .rr_last (rr_last_q),
        .gnt     (gnt),
        .any     (any)
    );

    assign can_accept = !reset && (state_q != ST_HI);
    assign ready_l0   = can_accept && valid_l0 && !gnt;
    assign ready_l1   = can_accept && valid_l1 && gnt;
    assign word       = gnt ? data_l1 : data_l0;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        data_d    = data_q;
        valid_d   = valid_q;
        lane_d    = lane_q;
        rr_last_d = rr_last_q;
        unique case (state_q)
            ST_HI: begin
                data_d  = hold_q;
                valid_d = 1'b1;
                state_d = ST_LO;
            end
            default: begin
                if (any) begin
                    data_d    = word[2*BYTE_W-1:BYTE_W];
                    hold_d    = word[BYTE_W-1:0];
                    valid_d   = 1'b1;
                    lane_d    = gnt;
                    rr_last_d = gnt;
                    state_d   = ST_HI;
                end else begin
                    data_d  = IDLE_BYTE;
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Reset drops any pending low byte and restarts with lane 0 priority.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            data_q    <= IDLE_BYTE;
            valid_q   <= 1'b0;
            lane_q    <= 1'b0;
            rr_last_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            lane_q    <= lane_d;
            rr_last_q <= rr_last_d;
        end
    end

    assign data_mux_l1  = data_q;
    assign valid_mux_l1 = valid_q;
    assign lane_mux_l1  = lane_q;

endmodule

// File: tb/tb_mux_l1_tx.sv
// Self-checking bench for mux_l1_tx: directed scenarios plus random
// traffic against a queue-based model of the byte stream.
module tb_mux_l1_tx;

    logic        clk_4f = 1'b0;
    logic        reset;
    logic [15:0] data_l0, data_l1;
    logic        valid_l0, valid_l1;
    logic        ready_l0, ready_l1;
    logic [7:0]  data_mux_l1;
    logic        valid_mux_l1;
    logic        lane_mux_l1;

    mux_l1_tx dut (
        .clk_4f       (clk_4f),
        .reset        (reset),
        .data_l0      (data_l0),
        .valid_l0     (valid_l0),
        .ready_l0     (ready_l0),
        .data_l1      (data_l1),
        .valid_l1     (valid_l1),
        .ready_l1     (ready_l1),
        .data_mux_l1  (data_mux_l1),
        .valid_mux_l1 (valid_mux_l1),
        .lane_mux_l1  (lane_mux_l1)
    );

    always #5 clk_4f = ~clk_4f;

    typedef struct {
        logic       lane;
        logic [7:0] b;
    } ob_t;

    int          checks = 0;
    int          fails  = 0;
    logic        rst    = 1'b1;
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic        pres0  = 1'b0;
    logic        pres1  = 1'b0;
    ob_t         pend[$];
    logic [7:0]  m_data = 8'hBC;
    logic        m_valid = 1'b0;
    logic        m_lane  = 1'b0;
    logic        m_last  = 1'b1;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h at %0t",
                   tag, obs, exp, $time);
        end
    endtask

    // One clock: present source words, check ready, then check outputs.
    task automatic cycle(input int pct);
        logic        er0, er1, ln, empty;
        logic [15:0] w;
        ob_t         o;
        if (!pres0 && q0.size() > 0 && $urandom_range(99) < pct) pres0 = 1'b1;
        if (!pres1 && q1.size() > 0 && $urandom_range(99) < pct) pres1 = 1'b1;
        reset    = rst;
        valid_l0 = pres0;
        valid_l1 = pres1;
        data_l0  = pres0 ? q0[0] : 16'($urandom);
        data_l1  = pres1 ? q1[0] : 16'($urandom);
        #1;
        empty = (pend.size() == 0);
        er0 = !rst && empty && pres0 && (!pres1 || m_last);
        er1 = !rst && empty && pres1 && (!pres0 || !m_last);
        chk("ready_l0", 16'(ready_l0), 16'(er0));
        chk("ready_l1", 16'(ready_l1), 16'(er1));
        if (rst) begin
            pend.delete();
            m_data  = 8'hBC;
            m_valid = 1'b0;
            m_lane  = 1'b0;
            m_last  = 1'b1;
        end else if (er0 || er1) begin
            ln = er1;
            if (ln) begin
                w = q1.pop_front();
                pres1 = 1'b0;
            end else begin
                w = q0.pop_front();
                pres0 = 1'b0;
            end
            m_last  = ln;
            m_lane  = ln;
            m_data  = w[15:8];
            m_valid = 1'b1;
            o.lane  = ln;
            o.b     = w[7:0];
            pend.push_back(o);
        end else if (pend.size() > 0) begin
            o       = pend.pop_front();
            m_data  = o.b;
            m_valid = 1'b1;
            m_lane  = o.lane;
        end else begin
            m_data  = 8'hBC;
            m_valid = 1'b0;
        end
        @(posedge clk_4f);
        #1;
        chk("data_mux_l1", 16'(data_mux_l1), 16'(m_data));
        chk("valid_mux_l1", 16'(valid_mux_l1), 16'(m_valid));
        chk("lane_mux_l1", 16'(lane_mux_l1), 16'(m_lane));
    endtask

    initial begin
        // 1: reset with both lanes valid
        q0.push_back(16'h5A5A);
        q1.push_back(16'hC3C3);
        rst = 1'b1;
        repeat (3) cycle(100);
        rst = 1'b0;
        repeat (4) cycle(100);
        // 2: single lane-0 word
        q0.push_back(16'hA1B2);
        repeat (4) cycle(100);
        // 3: lane 0 back-to-back
        q0.push_back(16'h0102);
        q0.push_back(16'h0304);
        repeat (6) cycle(100);
        // 4: both lanes always valid
        repeat (3) q0.push_back(16'h1111);
        repeat (3) q1.push_back(16'h2222);
        repeat (8) cycle(100);
        // 5: reset mid-word
        q0.push_back(16'hA1B2);
        cycle(100);
        rst = 1'b1;
        cycle(100);
        rst = 1'b0;
        repeat (2) cycle(100);
        // 6: idle then lane 1 alone
        repeat (5) cycle(100);
        q1.push_back(16'h7E81);
        repeat (3) cycle(100);
        // random traffic with occasional reset
        repeat (60) q0.push_back(16'($urandom));
        repeat (60) q1.push_back(16'($urandom));
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(99) < 2);
            cycle(60);
        end
        rst = 1'b0;
        repeat (300) begin
            if (q0.size() == 0 && q1.size() == 0 && pend.size() == 0)
                break;
            cycle(100);
        end
        repeat (2) cycle(100);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
